// File: rtl/exec_pkg.sv
// exec_pkg
//   Shared definitions for the execute result stage: ALU function codes,
//   condition-code bit positions and the condition-code reset value.
package exec_pkg;

    typedef enum logic [3:0] {
        ADDQ = 4'd0,
        SUBQ = 4'd1,
        ANDQ = 4'd2,
        XORQ = 4'd3
    } fn_e;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/exec_skid_buf.sv
// exec_skid_buf
//   Two-entry in-order buffer with a registered ready.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     upstream handshake (in_ready is a flop)
//     in_payload  [W]       entry written on input handshake
//     out_valid/out_ready   downstream handshake
//     out_payload [W]       head entry, forced to zero while empty
module exec_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload
);

    logic [W-1:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic         push;
    logic         pop;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count - 2'd1;
        end
    end

    // Ready is registered from the next occupancy, so out_ready never reaches
    // in_ready combinationally; a full buffer draining this cycle only opens
    // ready on the following one. Ready resets low and rises on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt != 2'd2);
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Storage needs no reset: occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            slot[wr_ptr] <= in_payload;
        end
    end

    assign out_payload = out_valid ? slot[rd_ptr] : '0;

endmodule

// File: rtl/exec_result_stage.sv
// exec_result_stage
//   Selects one ALU result channel by function code, buffers it in a
//   two-entry queue, and on retirement updates the condition-code register
//   and the sticky bad-function flag.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     in_valid/in_ready          upstream handshake
//     in_fn      [FN_W]          function code (channel select)
//     in_data    [NUM_OPS*WIDTH] packed channel results
//     in_cc      [NUM_OPS*CC_W]  packed channel condition codes
//     in_set_cc                  operation may update cc_q
//     out_valid/out_ready        downstream handshake
//     out_data, out_cc           head entry result and condition codes
//     out_bad_fn                 head entry had an out-of-range function code
//     cc_q                       architectural condition codes
//     err_clr, err_sticky        clear / sticky bad-function indication
module exec_result_stage
    import exec_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int NUM_OPS = 4,
    parameter int FN_W    = 4,
    parameter int CC_W    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FN_W-1:0]          in_fn,
    input  logic [NUM_OPS*WIDTH-1:0] in_data,
    input  logic [NUM_OPS*CC_W-1:0]  in_cc,
    input  logic                     in_set_cc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [CC_W-1:0]          out_cc,
    output logic                     out_bad_fn,
    output logic [CC_W-1:0]          cc_q,
    input  logic                     err_clr,
    output logic                     err_sticky
);

    // Entry layout: {set_cc, bad, cc, data}
    localparam int PW = WIDTH + CC_W + 2;

    logic [WIDTH-1:0] sel_data;
    logic [CC_W-1:0]  sel_cc;
    logic             sel_bad;
    logic [PW-1:0]    buf_in;
    logic [PW-1:0]    buf_out;
    logic             head_set_cc;
    logic             out_hs;

    // An unmatched code leaves data/cc at zero and marks the entry bad.
    always_comb begin
        sel_data = '0;
        sel_cc   = '0;
        sel_bad  = 1'b1;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (32'(in_fn) == k) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                sel_cc   = in_cc[k*CC_W +: CC_W];
                sel_bad  = 1'b0;
            end
        end
    end

    assign buf_in = {in_set_cc, sel_bad, sel_cc, sel_data};

    exec_skid_buf #(
        .W(PW)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_payload (buf_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_payload(buf_out)
    );

    assign out_data    = buf_out[WIDTH-1:0];
    assign out_cc      = buf_out[WIDTH +: CC_W];
    assign out_bad_fn  = buf_out[PW-2];
    assign head_set_cc = buf_out[PW-1];
    assign out_hs      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= CC_W'(CC_RESET);
        end else if (out_hs && head_set_cc && !out_bad_fn) begin
            cc_q <= out_cc;
        end
    end

    // A retiring bad entry wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (out_hs && out_bad_fn) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_result_stage.sv
module tb_exec_result_stage;
    import exec_pkg::*;

    localparam int WIDTH   = 64;
    localparam int NUM_OPS = 4;
    localparam int FN_W    = 4;
    localparam int CC_W    = 3;

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [FN_W-1:0]          in_fn;
    logic [NUM_OPS*WIDTH-1:0] in_data;
    logic [NUM_OPS*CC_W-1:0]  in_cc;
    logic                     in_set_cc;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [CC_W-1:0]          out_cc;
    logic                     out_bad_fn;
    logic [CC_W-1:0]          cc_q;
    logic                     err_clr;
    logic                     err_sticky;

    exec_result_stage #(
        .WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .FN_W(FN_W), .CC_W(CC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_fn(in_fn),
        .in_data(in_data), .in_cc(in_cc), .in_set_cc(in_set_cc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cc(out_cc), .out_bad_fn(out_bad_fn),
        .cc_q(cc_q), .err_clr(err_clr), .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CC_W-1:0]  cc;
        logic             bad;
        logic             set_cc;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               total = 0;
    int               bad   = 0;
    int               cyc   = 0;
    int               npops = 0;
    logic             mon_en = 1'b0;
    logic [CC_W-1:0]  m_cc  = 3'b100;
    logic             m_err = 1'b0;
    logic [WIDTH-1:0] ch_data [NUM_OPS];
    logic [CC_W-1:0]  ch_cc   [NUM_OPS];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: pick the channel by number; anything past the last channel is a bad op.
    function automatic exp_t model(input int fn, input logic sc);
        exp_t e;
        e.set_cc = sc;
        e.cyc    = cyc;
        if (fn < NUM_OPS) begin
            e.data = ch_data[fn];
            e.cc   = ch_cc[fn];
            e.bad  = 1'b0;
        end else begin
            e.data = '0;
            e.cc   = '0;
            e.bad  = 1'b1;
        end
        return e;
    endfunction

    task automatic rand_ch();
        for (int k = 0; k < NUM_OPS; k++) begin
            ch_data[k] = {$urandom, $urandom};
            ch_cc[k]   = CC_W'($urandom_range(0, 7));
        end
    endtask

    task automatic cycle(input logic v, input int fn, input logic sc, input logic ordy,
                         input logic clr, output logic acc);
        @(negedge clk);
        in_valid  = v;
        in_fn     = FN_W'(fn);
        in_set_cc = sc;
        out_ready = ordy;
        err_clr   = clr;
        for (int k = 0; k < NUM_OPS; k++) begin
            in_data[k*WIDTH +: WIDTH] = ch_data[k];
            in_cc[k*CC_W +: CC_W]     = ch_cc[k];
        end
        #1;
        acc = v && in_ready;
        if (acc) sb.push_back(model(fn, sc));
    endtask

    task automatic issue(input int fn, input logic sc, input logic ordy, output int tries);
        logic acc;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 50) begin
            cycle(1'b1, fn, sc, ordy, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL issue_timeout actual=not_accepted required=accepted fn=%0d", fn);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, ordy, 1'b0, acc);
    endtask

    // Monitor: checks visible state against the model each cycle, pops on handshake.
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [CC_W-1:0]  prev_cc;
    logic             prev_bad;

    always @(negedge clk) begin
        int   occ;
        exp_t h;
        #2;
        if (!mon_en) begin
            stall_prev = 1'b0;
        end else begin
            occ = sb.size();
            if (occ > 0 && sb[$].cyc == cyc) occ--;
            check("cc_q", 64'(cc_q), 64'(m_cc));
            check("err_sticky", 64'(err_sticky), 64'(m_err));
            check("out_valid", 64'(out_valid), 64'(occ > 0));
            check("in_ready", 64'(in_ready), 64'(occ < 2));
            if (!out_valid) begin
                check("idle_out_data", out_data, 64'd0);
                check("idle_out_cc", 64'(out_cc), 64'd0);
                check("idle_out_bad", 64'(out_bad_fn), 64'd0);
            end
            if (stall_prev && out_valid) begin
                check("stable_data", out_data, prev_data);
                check("stable_cc", 64'(out_cc), 64'(prev_cc));
                check("stable_bad", 64'(out_bad_fn), 64'(prev_bad));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_output actual=valid required=empty data=%0h", out_data);
                end else begin
                    h = sb.pop_front();
                    npops++;
                    check("out_data", out_data, h.data);
                    check("out_cc", 64'(out_cc), 64'(h.cc));
                    check("out_bad_fn", 64'(out_bad_fn), 64'(h.bad));
                    if (h.set_cc && !h.bad) m_cc = h.cc;
                    if (h.bad) m_err = 1'b1;
                    else if (err_clr) m_err = 1'b0;
                end
            end else if (err_clr) begin
                m_err = 1'b0;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_cc    = out_cc;
            prev_bad   = out_bad_fn;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tries;
        int   sum;
        int   p0;
        logic acc;

        rst_n = 1'b0; in_valid = 1'b0; in_fn = '0; in_data = '0; in_cc = '0;
        in_set_cc = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        rand_ch();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_cc_q", 64'(cc_q), 64'(3'b100));
        check("rst_err", 64'(err_sticky), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_cc", 64'(out_cc), 64'd0);
        check("rst_out_bad", 64'(out_bad_fn), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1'b1;

        // Channel 1 result 5 with cc 000 retires and loads cc_q
        rand_ch();
        ch_data[1] = 64'h5; ch_cc[1] = 3'b000;
        issue(SUBQ, 1'b1, 1'b1, tries);
        idle(2, 1'b1);
        check("dir_cc_q_load", 64'(cc_q), 64'(3'b000));

        // Out-of-range function code, then clear the sticky flag
        rand_ch();
        issue(7, 1'b1, 1'b1, tries);
        idle(2, 1'b1);
        check("dir_err_set", 64'(err_sticky), 64'd1);
        check("dir_bad_cc_hold", 64'(cc_q), 64'(3'b000));
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b1, acc);
        idle(1, 1'b1);
        check("dir_err_clr", 64'(err_sticky), 64'd0);

        // set_cc=0: cc is delivered but the register holds
        rand_ch();
        ch_cc[0] = 3'b011;
        issue(ADDQ, 1'b0, 1'b1, tries);
        idle(2, 1'b1);
        check("dir_no_set_cc", 64'(cc_q), 64'(3'b000));

        // Backpressure: A and B fill the buffer, C waits until the drain
        rand_ch(); issue(ANDQ, 1'b1, 1'b0, tries);
        rand_ch(); issue(XORQ, 1'b1, 1'b0, tries);
        idle(1, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        idle(2, 1'b0);
        rand_ch(); issue(SUBQ, 1'b1, 1'b1, tries);
        check("full_c_stalled", 64'(tries), 64'd2);
        idle(3, 1'b1);

        // Streaming: 100 in-range ops at one per cycle
        p0 = npops; sum = 0;
        for (int i = 0; i < 100; i++) begin
            rand_ch();
            issue($urandom_range(0, NUM_OPS - 1), 1'($urandom), 1'b1, tries);
            sum += tries;
        end
        idle(3, 1'b1);
        check("stream_cycles", 64'(sum), 64'd100);
        check("stream_outputs", 64'(npops - p0), 64'd100);

        // Random traffic including bad codes, stalls and clears
        for (int i = 0; i < 400; i++) begin
            rand_ch();
            cycle(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), acc);
        end
        idle(4, 1'b1);

        // Reset with two entries held
        rand_ch(); issue(6, 1'b1, 1'b1, tries);
        rand_ch(); ch_cc[2] = 3'b011; issue(ANDQ, 1'b1, 1'b1, tries);
        idle(3, 1'b1);
        rand_ch(); issue(ADDQ, 1'b1, 1'b0, tries);
        rand_ch(); issue(SUBQ, 1'b1, 1'b0, tries);
        idle(1, 1'b0);
        @(negedge clk);
        mon_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_cc_q", 64'(cc_q), 64'(3'b100));
        check("mid_rst_err", 64'(err_sticky), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        sb.delete();
        m_cc = 3'b100; m_err = 1'b0;
        idle(2, 1'b1);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_out_valid", 64'(out_valid), 64'd0);
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_ch();
            issue($urandom_range(0, 7), 1'($urandom), 1'b1, tries);
        end
        idle(4, 1'b1);
        check("drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
